// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: walks a 4:1 mux select through 0..3, holding each for DWELL clocks, and packs the sampled outputs into one word.
// Optional macro MUX_SCAN_PARITY_EN adds a registered parity output alongside data.
module mux_scan_ctrl #(
    parameter int unsigned DWELL = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       continuous,
    input  logic       y,
    output logic [1:0] s,
    output logic [3:0] data,
    output logic       valid,
`ifdef MUX_SCAN_PARITY_EN
    output logic       parity,
`endif
    output logic       busy
);
    if (DWELL < 1 || DWELL > 15) begin : g_dwell_chk
        $error("mux_scan_ctrl: DWELL must be in 1..15");
    end

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;
    localparam logic [3:0] RELOAD = 4'(DWELL - 1);

    logic [0:0] state_q, state_d;
    logic [1:0] s_q, s_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] cap_q, cap_d;
    logic [3:0] data_q, data_d;
    logic       valid_q, valid_d;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        data_d  = data_q;
        valid_d = 1'b0;
        if (state_q == IDLE) begin
            if (start) begin
                state_d = SCAN;
                s_d     = 2'd0;
                cnt_d   = RELOAD;
            end
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end else begin
            cnt_d        = RELOAD;
            cap_d[s_q]   = y;
            s_d          = s_q + 2'd1;
            // Channel 3 bypasses the capture register so the word is ready on the sampling edge
            if (s_q == 2'd3) begin
                data_d  = {y, cap_q[2:0]};
                valid_d = 1'b1;
                state_d = continuous ? SCAN : IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= 2'd0;
            cnt_q   <= 4'd0;
            cap_q   <= 4'd0;
            data_q  <= 4'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

`ifdef MUX_SCAN_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) parity_q <= 1'b0;
        else     parity_q <= ^data_d;
    end

    assign parity = parity_q;
`endif

    assign s     = s_q;
    assign data  = data_q;
    assign valid = valid_q;
    assign busy  = state_q;
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: randomized and directed stimulus for mux_scan_ctrl, checked against an elapsed-time reference model.
module tb_mux_scan_ctrl;
    localparam int D = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       continuous = 1'b0;
    logic [3:0] iv = 4'b0000;
    logic       y;
    logic [1:0] s;
    logic [3:0] data;
    logic       valid;
    logic       busy;
    logic       par_o;
    int         checks = 0;
    int         passed = 0;

    always #5 clk = ~clk;

    assign y = iv[s];

    mux_scan_ctrl #(.DWELL(D)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .continuous(continuous),
        .y(y),
        .s(s),
        .data(data),
        .valid(valid),
`ifdef MUX_SCAN_PARITY_EN
        .parity(par_o),
`endif
        .busy(busy)
    );

`ifndef MUX_SCAN_PARITY_EN
    assign par_o = 1'b0;
`endif

    // Reference: m_t counts clocks since the accepting edge; channel k is sampled when m_t reaches (k+1)*D
    logic       m_busy = 1'b0;
    int         m_t = 0;
    logic [3:0] m_cap = 4'b0, m_data = 4'b0, m_nc;
    logic       m_valid = 1'b0, m_par = 1'b0;
    int         m_nt;
    logic [1:0] m_ch, m_s;

    assign m_nt = m_t + 1;
    assign m_ch = 2'((m_nt / D) - 1);
    assign m_s  = m_busy ? 2'(m_t / D) : 2'd0;

    always_comb begin
        m_nc = m_cap;
        if (m_nt % D == 0) m_nc[m_ch] = iv[m_ch];
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0; m_t <= 0; m_cap <= 4'b0; m_data <= 4'b0; m_valid <= 1'b0; m_par <= 1'b0;
        end else begin
            m_valid <= 1'b0;
            if (!m_busy) begin
                if (start) begin m_busy <= 1'b1; m_t <= 0; end
            end else begin
                m_cap <= m_nc;
                m_t   <= m_nt;
                if (m_nt == 4 * D) begin
                    m_data  <= m_nc;
                    m_par   <= ^m_nc;
                    m_valid <= 1'b1;
                    m_t     <= 0;
                    if (!continuous) m_busy <= 1'b0;
                end
            end
        end
    end

    logic [8:0] obs, exp_o;
    assign obs = {s, data, valid, busy, par_o};
`ifdef MUX_SCAN_PARITY_EN
    assign exp_o = {m_s, m_data, m_valid, m_busy, m_par};
`else
    assign exp_o = {m_s, m_data, m_valid, m_busy, 1'b0};
`endif

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (obs !== 9'd0) $display("FAIL reset_state got %b want %b", obs, 9'd0); else passed++;
        checks++;
        if (obs !== exp_o) $display("FAIL reset_model got %b want %b", obs, exp_o); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_single();
        int nv = 0;
        logic [3:0] seen = 4'b0;
        iv = 4'b1011; continuous = 1'b0; start = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (obs !== exp_o) $display("FAIL single c=%0d got %b want %b", c, obs, exp_o); else passed++;
            if (valid) begin nv++; seen = data; end
        end
        checks++;
        if (nv !== 1 || seen !== 4'b1011) $display("FAIL single_word got %0d/%b want 1/1011", nv, seen); else passed++;
    endtask

    task automatic test_continuous();
        int nv = 0;
        int last = -1;
        iv = 4'b0110; continuous = 1'b1; start = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (obs !== exp_o) $display("FAIL cont c=%0d got %b want %b", c, obs, exp_o); else passed++;
            if (valid) begin
                nv++;
                if (nv == 1) begin
                    checks++;
                    if (data !== 4'b0110) $display("FAIL cont_first got %b want 0110", data); else passed++;
                end
                if (nv == 3) begin
                    checks++;
                    if (data !== 4'b1001) $display("FAIL cont_third got %b want 1001", data); else passed++;
                end
                if (last >= 0) begin
                    checks++;
                    if (c - last !== 4 * D) $display("FAIL cont_gap got %0d want %0d", c - last, 4 * D); else passed++;
                end
                last = c;
            end
            if (c == 11) iv = 4'b1001;
            if (c == 20) continuous = 1'b0;
        end
        checks++;
        if (nv !== 3 || busy !== 1'b0) $display("FAIL cont_count got %0d/%b want 3/0", nv, busy); else passed++;
    endtask

    task automatic test_busy_start();
        int nv = 0;
        iv = 4'b1100; continuous = 1'b0; start = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            start = (c == 2);
            checks++;
            if (obs !== exp_o) $display("FAIL busy_start c=%0d got %b want %b", c, obs, exp_o); else passed++;
            nv += int'(valid);
        end
        checks++;
        if (nv !== 1) $display("FAIL busy_start_count got %0d want 1", nv); else passed++;
    endtask

    task automatic test_reset_mid();
        int nv = 0;
        iv = 4'b1111; continuous = 1'b0; start = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        checks++;
        if (s !== 2'd2) $display("FAIL rst_mid_pre got s=%0d want 2", s); else passed++;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({s, data, valid, busy} !== 8'd0) $display("FAIL rst_mid_async got %b want 0", {s, data, valid, busy}); else passed++;
        @(negedge clk);
        checks++;
        if (obs !== exp_o || valid !== 1'b0) $display("FAIL rst_mid_hold got %b want %b", obs, exp_o); else passed++;
        rst = 1'b0; start = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (obs !== exp_o) $display("FAIL rst_mid c=%0d got %b want %b", c, obs, exp_o); else passed++;
            if (valid) begin
                nv++;
                checks++;
                if (c !== 4 * D || data !== 4'b1111) $display("FAIL rst_mid_word got c=%0d/%b want %0d/1111", c, data, 4 * D); else passed++;
            end
        end
        checks++;
        if (nv !== 1) $display("FAIL rst_mid_count got %0d want 1", nv); else passed++;
    endtask

    task automatic test_back_to_back();
        int nv = 0;
        int last = -1;
        iv = 4'b0101; continuous = 1'b0; start = 1'b1;
        for (int c = 0; c < 52; c++) begin
            @(negedge clk);
            if (c >= 40) start = 1'b0;
            checks++;
            if (obs !== exp_o) $display("FAIL b2b c=%0d got %b want %b", c, obs, exp_o); else passed++;
            if (valid) begin
                nv++;
                checks++;
                if (data !== 4'b0101) $display("FAIL b2b_word got %b want 0101", data); else passed++;
                if (last >= 0) begin
                    checks++;
                    if (c - last !== 4 * D + 1) $display("FAIL b2b_gap got %0d want %0d", c - last, 4 * D + 1); else passed++;
                end
                last = c;
            end
        end
        checks++;
        if (nv !== 5) $display("FAIL b2b_count got %0d want 5", nv); else passed++;
    endtask

`ifdef MUX_SCAN_PARITY_EN
    task automatic test_parity();
        logic [3:0] pats [2] = '{4'b0111, 4'b0110};
        logic       want [2] = '{1'b1, 1'b0};
        for (int p = 0; p < 2; p++) begin
            iv = pats[p]; continuous = 1'b0; start = 1'b1;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                start = 1'b0;
                if (valid) begin
                    checks++;
                    if (par_o !== want[p] || data !== pats[p]) $display("FAIL parity p=%0d got %b/%b want %b/%b", p, par_o, data, want[p], pats[p]); else passed++;
                end
            end
        end
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_o) $display("FAIL random c=%0d got %b want %b", c, obs, exp_o); else passed++;
            start = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0) continuous = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) iv = 4'($urandom);
            if (c >= 380) begin start = 1'b0; continuous = 1'b0; end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_continuous();
        test_busy_start();
        test_reset_mid();
        test_back_to_back();
`ifdef MUX_SCAN_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
